// File: rtl/lzrw1_stream_decompressor.sv
// LZRW1 stream decompressor: one compressed item per input handshake, one
// output byte per cycle on a valid/ready stream, with a circular history window.
// Optional offset legality checking is enabled by defining DECOMP_OFFSET_CHECK_EN.
module lzrw1_stream_decompressor #(
    parameter int HISTORY_SIZE = 256,
    parameter int LEN_WIDTH    = 4,
    parameter int MIN_MATCH    = 3,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [15:0]            data_in,
    input  logic                   control_word_in,
    input  logic                   in_last,
    input  logic                   data_in_valid,
    output logic                   in_ready,
    output logic [7:0]             decompressed_byte,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   error
);

    localparam int AW    = $clog2(HISTORY_SIZE);
    localparam int OFF_W = 16 - LEN_WIDTH;
    localparam int REM_W = $clog2((1 << LEN_WIDTH) + MIN_MATCH);
    localparam logic [AW:0] FILL_MAX = (AW+1)'(HISTORY_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_COPY, S_ERR} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]            fill_q, fill_d;
    logic [REM_W-1:0]       remaining_q, remaining_d;
    logic [AW-1:0]          offset_q, offset_d;
    logic                   copy_last_q, copy_last_d;
    logic                   out_valid_q, out_valid_d;
    logic [7:0]             out_byte_q, out_byte_d;
    logic                   out_last_q, out_last_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   error_q, error_d;

    logic [7:0]       hist_mem [HISTORY_SIZE];
    logic [AW-1:0]    rd_addr;
    logic [7:0]       hist_rdata;
    logic             slot_free, in_fire, illegal;
    logic [OFF_W-1:0] offset_in;
    logic [REM_W-1:0] copy_len;
    logic             emit, emit_last;
    logic [7:0]       emit_byte;

    assign slot_free = !out_valid_q || out_ready;
    // Gating with the reset pin keeps in_ready low while reset is held.
    assign in_ready  = reset && (state_q == S_IDLE) && slot_free;
    assign in_fire   = data_in_valid && in_ready;
    assign offset_in = data_in[15:LEN_WIDTH];
    assign copy_len  = REM_W'(data_in[LEN_WIDTH-1:0]) + REM_W'(MIN_MATCH);

    // The copy source trails the write pointer by the offset; an accepting copy
    // uses the incoming offset, a running copy the latched one.
    assign rd_addr    = wr_ptr_q - ((state_q == S_COPY) ? offset_q : AW'(offset_in));
    assign hist_rdata = hist_mem[rd_addr];

`ifdef DECOMP_OFFSET_CHECK_EN
    assign illegal = (offset_in == '0) || (32'(offset_in) > 32'(fill_q));
`else
    assign illegal = 1'b0;
`endif

    assign decompressed_byte = out_byte_q;
    assign out_valid         = out_valid_q;
    assign out_last          = out_last_q;
    assign out_count         = count_q;
    assign error             = error_q;

    // Next-state and datapath: decode items, run copies, load the output slot.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        remaining_d = remaining_q;
        offset_d    = offset_q;
        copy_last_d = copy_last_q;
        out_valid_d = out_ready ? 1'b0 : out_valid_q;
        out_last_d  = out_ready ? 1'b0 : out_last_q;
        out_byte_d  = out_byte_q;
        count_d     = count_q + COUNT_WIDTH'(out_valid_q && out_ready);
        error_d     = error_q;
        emit        = 1'b0;
        emit_byte   = 8'h00;
        emit_last   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    if (!control_word_in) begin
                        emit      = 1'b1;
                        emit_byte = data_in[7:0];
                        emit_last = in_last;
                    end else if (illegal) begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        // First copy byte leaves in the accept cycle itself.
                        emit        = 1'b1;
                        emit_byte   = hist_rdata;
                        emit_last   = in_last && (copy_len == REM_W'(1));
                        offset_d    = AW'(offset_in);
                        remaining_d = copy_len - REM_W'(1);
                        copy_last_d = in_last;
                        if (copy_len != REM_W'(1)) state_d = S_COPY;
                    end
                end
            end
            S_COPY: begin
                if (slot_free) begin
                    emit        = 1'b1;
                    emit_byte   = hist_rdata;
                    emit_last   = copy_last_q && (remaining_q == REM_W'(1));
                    remaining_d = remaining_q - REM_W'(1);
                    if (remaining_q == REM_W'(1)) state_d = S_IDLE;
                end
            end
            S_ERR: begin
            end
            default: state_d = S_IDLE;
        endcase

        if (emit) begin
            out_valid_d = 1'b1;
            out_byte_d  = emit_byte;
            out_last_d  = emit_last;
            wr_ptr_d    = wr_ptr_q + AW'(1);
            fill_d      = emit_last ? '0 :
                          ((fill_q == FILL_MAX) ? fill_q : fill_q + (AW+1)'(1));
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            remaining_q <= '0;
            offset_q    <= '0;
            copy_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
            out_last_q  <= 1'b0;
            count_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            remaining_q <= remaining_d;
            offset_q    <= offset_d;
            copy_last_q <= copy_last_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_last_q  <= out_last_d;
            count_q     <= count_d;
            error_q     <= error_d;
        end
    end

    // History write of every emitted byte.
    // NOTE: the history array is deliberately not reset; its contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (emit) hist_mem[wr_ptr_q] <= emit_byte;
    end

endmodule

// File: tb/tb_lzrw1_stream_decompressor.sv
// Directed self-checking bench for lzrw1_stream_decompressor.
// Inputs change 1 time unit after a rising edge; outputs are sampled on falling edges.
module tb_lzrw1_stream_decompressor;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        control_word_in;
    logic        in_last;
    logic        data_in_valid;
    logic        in_ready;
    logic [7:0]  decompressed_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [31:0] out_count;
    logic        error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Monitor state: accepted bytes, their last flags and falling-edge cycle stamps.
    logic [7:0] byte_q [$];
    logic       last_q [$];
    int         stamp_q [$];
    int         stall_cnt = 0;
    int         stall_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic       prev_last = 1'b0;
    logic       toggle_en = 1'b0;

    lzrw1_stream_decompressor dut (
        .clock             (clock),
        .reset             (reset),
        .data_in           (data_in),
        .control_word_in   (control_word_in),
        .in_last           (in_last),
        .data_in_valid     (data_in_valid),
        .in_ready          (in_ready),
        .decompressed_byte (decompressed_byte),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last          (out_last),
        .out_count         (out_count),
        .error             (error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record handshakes that will complete at the next rising edge; watch stalled bytes stay put.
    initial begin
        forever begin
            @(negedge clock);
            if (out_valid && out_ready) begin
                byte_q.push_back(decompressed_byte);
                last_q.push_back(out_last);
                stamp_q.push_back(cyc);
            end
            if (prev_stall && (!out_valid || decompressed_byte !== prev_byte || out_last !== prev_last))
                stall_viol++;
            prev_stall = out_valid && !out_ready;
            prev_byte  = decompressed_byte;
            prev_last  = out_last;
            if (prev_stall) stall_cnt++;
        end
    end

    // Sink back-pressure pattern 1,0,0 repeating while enabled.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clock);
            #1;
            if (toggle_en) begin
                out_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
        end
    end

    task automatic clear_mon();
        byte_q.delete();
        last_q.delete();
        stamp_q.delete();
        stall_cnt  = 0;
        stall_viol = 0;
    endtask

    task automatic idle_inputs();
        data_in         = 16'h0000;
        control_word_in = 1'b0;
        in_last         = 1'b0;
        data_in_valid   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        toggle_en = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        clear_mon();
    endtask

    // Present one item and hold it until accepted (bounded); returns the accept cycle stamp.
    task automatic send(input logic cw, input logic [15:0] d, input logic last, output int acc);
        data_in         = d;
        control_word_in = cw;
        in_last         = last;
        data_in_valid   = 1'b1;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clock);
        #1;
        idle_inputs();
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout item %h not accepted within 50 cycles", d);
        end
    endtask

    task automatic check_bytes(input string name, input string exp);
        checks++;
        if (byte_q.size() !== exp.len()) begin
            errors++;
            $display("FAIL %s_count got %0d bytes want %0d", name, byte_q.size(), exp.len());
        end else begin
            for (int i = 0; i < exp.len(); i++) begin
                checks++;
                if (byte_q[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL %s_byte%0d got %h want %h", name, i, byte_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b1;
        reset = 1'b0;
        #12;
        checks++;
        if ({in_ready, out_valid, out_last, error} !== 4'b0000 || out_count !== 32'd0 ||
            decompressed_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b last=%b err=%b cnt=%0d byte=%h want all 0",
                     in_ready, out_valid, out_last, error, out_count, decompressed_byte);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready got %b want 1", in_ready);
        end
        clear_mon();
    endtask

    task automatic test_literals();
        int acc [3];
        string s = "abc";
        do_reset();
        for (int i = 0; i < 3; i++) send(1'b0, {8'h00, s[i]}, i == 2, acc[i]);
        repeat (4) @(posedge clock);
        #1;
        check_bytes("lit", "abc");
        for (int i = 0; i < 3 && i < stamp_q.size(); i++) begin
            checks++;
            if (stamp_q[i] !== acc[i] + 1) begin
                errors++;
                $display("FAIL lit_latency%0d got cycle %0d want %0d", i, stamp_q[i], acc[i] + 1);
            end
        end
        checks++;
        if (acc[1] !== acc[0] + 1 || acc[2] !== acc[1] + 1) begin
            errors++;
            $display("FAIL lit_back_to_back got accepts %0d %0d %0d want consecutive", acc[0], acc[1], acc[2]);
        end
        checks++;
        if (last_q.size() == 3 && (last_q[2] !== 1'b1 || last_q[0] !== 1'b0)) begin
            errors++;
            $display("FAIL lit_last got %b%b%b want 001", last_q[0], last_q[1], last_q[2]);
        end
        checks++;
        if (out_count !== 32'd3) begin
            errors++;
            $display("FAIL lit_out_count got %0d want 3", out_count);
        end
    endtask

    task automatic test_copy();
        int acc;
        logic [2:0] rdy;
        string s = "abc";
        do_reset();
        for (int i = 0; i < 3; i++) send(1'b0, {8'h00, s[i]}, 1'b0, acc);
        send(1'b1, 16'h0030, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            rdy[i] = in_ready;
        end
        checks++;
        if (rdy !== 3'b100) begin
            errors++;
            $display("FAIL copy_in_ready got %b want 100 (cycles +1,+2,+3)", rdy);
        end
        repeat (3) @(posedge clock);
        #1;
        check_bytes("copy", "abcabc");
        checks++;
        if (stamp_q.size() == 6 &&
            (stamp_q[3] !== acc + 1 || stamp_q[4] !== acc + 2 || stamp_q[5] !== acc + 3)) begin
            errors++;
            $display("FAIL copy_timing got %0d %0d %0d want %0d %0d %0d",
                     stamp_q[3], stamp_q[4], stamp_q[5], acc + 1, acc + 2, acc + 3);
        end
        checks++;
        if (last_q.size() == 6 && (last_q[5] !== 1'b1 || last_q[4] !== 1'b0 || last_q[3] !== 1'b0)) begin
            errors++;
            $display("FAIL copy_last got %b%b%b want 001", last_q[3], last_q[4], last_q[5]);
        end
    endtask

    task automatic test_overlap();
        int acc;
        do_reset();
        send(1'b0, 16'h0078, 1'b0, acc);
        send(1'b1, 16'h0012, 1'b0, acc);
        repeat (8) @(posedge clock);
        #1;
        check_bytes("overlap", "xxxxxx");
        checks++;
        if (out_count !== 32'd6) begin
            errors++;
            $display("FAIL overlap_out_count got %0d want 6", out_count);
        end
    endtask

    task automatic test_back_pressure();
        int acc;
        string s = "abc";
        do_reset();
        toggle_en = 1'b1;
        for (int i = 0; i < 3; i++) send(1'b0, {8'h00, s[i]}, 1'b0, acc);
        send(1'b1, 16'h0030, 1'b0, acc);
        repeat (30) @(posedge clock);
        #1;
        toggle_en = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_bytes("stall", "abcabc");
        checks++;
        if (stall_viol !== 0) begin
            errors++;
            $display("FAIL stall_hold got %0d changed stalled bytes want 0", stall_viol);
        end
        checks++;
        if (stall_cnt == 0) begin
            errors++;
            $display("FAIL stall_seen got %0d stalled cycles want >0", stall_cnt);
        end
        checks++;
        if (out_count !== 32'd6) begin
            errors++;
            $display("FAIL stall_out_count got %0d want 6", out_count);
        end
    endtask

`ifdef DECOMP_OFFSET_CHECK_EN
    task automatic test_offset_check();
        int acc;
        logic bad;
        do_reset();
        send(1'b1, 16'h0000, 1'b0, acc);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || error !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL err_offset0 got rdy=%b vld=%b err=%b want 0 0 1", in_ready, out_valid, error);
        end
        check_bytes("err_offset0", "");
        do_reset();
        send(1'b0, 16'h0070, 1'b0, acc);
        send(1'b0, 16'h0071, 1'b0, acc);
        send(1'b1, 16'h0050, 1'b0, acc);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || error !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL err_offset_fill got rdy=%b vld=%b err=%b want 0 0 1", in_ready, out_valid, error);
        end
        check_bytes("err_offset_fill", "pq");
    endtask
`else
    task automatic test_offset_check();
        int acc;
        do_reset();
        send(1'b1, 16'h0000, 1'b0, acc);
        repeat (6) @(posedge clock);
        #1;
        checks++;
        if (byte_q.size() !== 3 || error !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL nocheck_offset0 got bytes=%0d err=%b rdy=%b want 3 0 1",
                     byte_q.size(), error, in_ready);
        end
    endtask
`endif

    task automatic test_reset_mid_copy();
        int acc;
        do_reset();
        send(1'b0, 16'h006b, 1'b0, acc);
        send(1'b1, 16'h0013, 1'b0, acc);
        @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b1 || decompressed_byte !== 8'h6b) begin
            errors++;
            $display("FAIL midcopy_second_byte got vld=%b byte=%h want 1 6b", out_valid, decompressed_byte);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, error} !== 4'b0000 || out_count !== 32'd0 ||
            decompressed_byte !== 8'h00) begin
            errors++;
            $display("FAIL midcopy_reset got rdy=%b vld=%b last=%b err=%b cnt=%0d byte=%h want all 0",
                     in_ready, out_valid, out_last, error, out_count, decompressed_byte);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        clear_mon();
        send(1'b0, 16'h007a, 1'b1, acc);
        repeat (8) @(posedge clock);
        #1;
        check_bytes("after_reset", "z");
        checks++;
        if (out_count !== 32'd1 || (last_q.size() == 1 && last_q[0] !== 1'b1)) begin
            errors++;
            $display("FAIL after_reset_count got cnt=%0d want 1 with last", out_count);
        end
    endtask

    initial begin
        test_reset();
        test_literals();
        test_copy();
        test_overlap();
        test_back_pressure();
        test_offset_check();
        test_reset_mid_copy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
